// File: rtl/bram_burst_reader.sv
// rtl/bram_burst_reader.sv - burst read initiator for the BRAM controller with return FIFO and output stream
// Optional BURST_RD_STRIDE_EN adds a per-burst cfg_stride input in place of the fixed ADDR_STEP increment.
module bram_burst_reader #(
  parameter int DAT_WIDTH  = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LEN_WIDTH  = 16,
  parameter int FIFO_DEPTH = 4,
  parameter int ADDR_STEP  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_start,
  input  logic [ADDR_WIDTH-1:0] cfg_addr,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
`ifdef BURST_RD_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] cfg_stride,
`endif
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] ctrl_addr,
  output logic                  ctrl_rden,
  output logic                  ctrl_wren,
  output logic [DAT_WIDTH-1:0]  ctrl_idat,
  input  logic [DAT_WIDTH-1:0]  ctrl_odat,
  input  logic                  ctrl_oval,
  output logic [DAT_WIDTH-1:0]  m_dat,
  output logic                  m_val,
  input  logic                  m_rdy,
  output logic                  m_last
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [ADDR_WIDTH-1:0] step;
  logic [LEN_WIDTH-1:0]  issue_rem;
  logic [LEN_WIDTH-1:0]  pop_rem;
  logic [DAT_WIDTH-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]         wptr;
  logic [PW-1:0]         rptr;
  logic [CW-1:0]         count;
  logic [CW:0]           occ;
  logic                  inflight;
  logic                  drop;
  logic                  push;
  logic                  pop;

`ifdef BURST_RD_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q;
  assign step = stride_q;
`else
  assign step = ADDR_WIDTH'(ADDR_STEP);
`endif

  assign ctrl_wren = 1'b0;
  assign ctrl_idat = '0;
  assign ctrl_addr = cur_addr;

  // Occupancy counts entries in the FIFO plus the read already on the wire.
  assign pop       = m_val & m_rdy;
  assign occ       = {1'b0, count} + (CW+1)'(inflight) - (CW+1)'(pop);
  assign ctrl_rden = (state == ISSUE) && (occ < (CW+1)'(FIFO_DEPTH));

  // A return landing right after reset belongs to the aborted burst.
  assign push = ctrl_oval & ~drop;

  assign m_val  = (count != '0);
  assign m_dat  = m_val ? mem[rptr] : '0;
  assign m_last = m_val & (pop_rem == LEN_WIDTH'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cur_addr  <= '0;
      issue_rem <= '0;
      pop_rem   <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      inflight  <= 1'b0;
      drop      <= 1'b1;
`ifdef BURST_RD_STRIDE_EN
      stride_q  <= ADDR_WIDTH'(ADDR_STEP);
`endif
    end else begin
      inflight <= ctrl_rden;
      drop     <= 1'b0;
      done     <= 1'b0;
      if (pop)
        pop_rem <= pop_rem - LEN_WIDTH'(1);
      case (state)
        IDLE: begin
          if (cfg_start) begin
            if (cfg_len != '0) begin
              cur_addr  <= cfg_addr;
              issue_rem <= cfg_len;
              pop_rem   <= cfg_len;
              busy      <= 1'b1;
              state     <= ISSUE;
`ifdef BURST_RD_STRIDE_EN
              stride_q  <= cfg_stride;
`endif
            end else begin
              done <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (ctrl_rden) begin
            cur_addr  <= cur_addr + step;
            issue_rem <= issue_rem - LEN_WIDTH'(1);
            if (issue_rem == LEN_WIDTH'(1))
              state <= DRAIN;
          end
        end
        DRAIN: begin
          if (pop && pop_rem == LEN_WIDTH'(1)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + PW'(1);
      if (pop)
        rptr <= rptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wptr] <= ctrl_odat;
  end
endmodule

// File: tb/tb_bram_burst_reader.sv
// tb/tb_bram_burst_reader.sv - scoreboard bench for bram_burst_reader with a behavioural BRAM model
// Define BURST_RD_STRIDE_EN to match a stride-enabled build of the design.
module tb_bram_burst_reader;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_start = 1'b0;
  logic [31:0] cfg_addr = '0;
  logic [15:0] cfg_len = '0;
  logic [31:0] cfg_stride = 32'd4;
  logic        busy, done, ctrl_rden, ctrl_wren, m_val, m_last;
  logic [31:0] ctrl_addr, ctrl_idat, m_dat;
  logic [31:0] bram_odat = '0;
  logic        bram_oval = 1'b0;
  logic        m_rdy = 1'b0;

  int total = 0;
  int bad = 0;
  int rdy_mode = 1;
  int exp_done = 0;
  int done_cnt = 0;
  int rden_cnt = 0;
  int pop_cnt = 0;
  int cyc = 0;
  int last_hs_cyc = 0;
  bit last_pending = 0;

  logic [31:0] addr_q[$];
  logic [31:0] data_q[$];
  bit          last_q[$];

  bram_burst_reader dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_addr(cfg_addr), .cfg_len(cfg_len),
`ifdef BURST_RD_STRIDE_EN
    .cfg_stride(cfg_stride),
`endif
    .busy(busy), .done(done), .ctrl_addr(ctrl_addr), .ctrl_rden(ctrl_rden),
    .ctrl_wren(ctrl_wren), .ctrl_idat(ctrl_idat), .ctrl_odat(bram_odat),
    .ctrl_oval(bram_oval), .m_dat(m_dat), .m_val(m_val), .m_rdy(m_rdy), .m_last(m_last)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Controller model: one-cycle read latency, garbage on odat when not valid.
  always @(posedge clk) begin
    bram_oval <= ctrl_rden;
    bram_odat <= ctrl_rden ? mem_word(ctrl_addr) : $urandom;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0: m_rdy = 1'b0;
      1: m_rdy = 1'b1;
      default: m_rdy = 1'($urandom_range(0, 1));
    endcase
  end

  always @(negedge clk) begin
    cyc++;
    if (!rst) begin
      if (ctrl_rden) begin
        rden_cnt++;
        if (addr_q.size() == 0) chk("unexpected_issue", ctrl_addr, 64'hDEAD);
        else chk("issue_addr", ctrl_addr, addr_q.pop_front());
      end
      if (m_val && m_rdy) begin
        pop_cnt++;
        if (data_q.size() == 0) chk("unexpected_beat", m_dat, 64'hDEAD);
        else begin
          chk("beat_data", m_dat, data_q.pop_front());
          chk("beat_last", m_last, last_q.pop_front());
          if (m_last) begin last_pending = 1; last_hs_cyc = cyc; end
        end
      end
      if (done) begin
        done_cnt++;
        chk("done_busy_low", busy, 0);
        if (last_pending) begin
          chk("done_timing", cyc, last_hs_cyc + 1);
          last_pending = 0;
        end
      end
    end
  end

  task automatic start_burst(input logic [31:0] a, input logic [15:0] len);
    logic [31:0] s;
`ifdef BURST_RD_STRIDE_EN
    s = cfg_stride;
`else
    s = 32'd4;
`endif
    for (int i = 0; i < int'(len); i++) begin
      addr_q.push_back(a + s * i);
      data_q.push_back(mem_word(a + s * i));
      last_q.push_back(i == int'(len) - 1);
    end
    exp_done++;
    @(posedge clk); #1;
    cfg_start = 1'b1; cfg_addr = a; cfg_len = len;
    @(posedge clk); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    while ((busy || data_q.size() != 0) && n < budget) begin
      @(posedge clk); #1; n++;
    end
    chk("idle_reached", {busy, 31'(data_q.size())}, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rden"}, ctrl_rden, 0);
    chk({tag, "_addr"}, ctrl_addr, 0);
    chk({tag, "_mval"}, m_val, 0);
    chk({tag, "_mlast"}, m_last, 0);
    chk({tag, "_mdat"}, m_dat, 0);
    chk({tag, "_wren_idat"}, {ctrl_wren, ctrl_idat}, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_outputs("reset");

    // basic burst with start-to-data latency
    rdy_mode = 1;
    repeat (2) @(posedge clk);
    start_burst(32'h100, 16'd4);
    @(negedge clk);
    chk("start_busy", busy, 1);
    chk("start_rden", ctrl_rden, 1);
    @(negedge clk);
    chk("mval_cycle2", m_val, 0);
    @(negedge clk);
    chk("mval_cycle3", m_val, 1);
    wait_idle(100);
    chk("basic_done_count", done_cnt, exp_done);

    // backpressure: exactly FIFO_DEPTH reads issued while stalled
    rdy_mode = 0;
    repeat (2) @(posedge clk);
    base = rden_cnt;
    start_burst(32'h400, 16'd10);
    repeat (20) @(posedge clk);
    #1;
    chk("stall_issue_count", rden_cnt - base, 4);
    chk("stall_mval", m_val, 1);
    rdy_mode = 1;
    wait_idle(200);
    chk("bp_done_count", done_cnt, exp_done);

    // zero length
    start_burst(32'h500, 16'd0);
    @(negedge clk);
    chk("zero_done", done, 1);
    chk("zero_busy", busy, 0);
    chk("zero_rden", ctrl_rden, 0);
    @(negedge clk);
    chk("zero_done_once", done, 0);
    chk("zero_done_count", done_cnt, exp_done);

    // second start while busy is ignored
    rdy_mode = 0;
    start_burst(32'h300, 16'd6);
    repeat (3) @(posedge clk);
    #1 cfg_start = 1'b1; cfg_addr = 32'h900; cfg_len = 16'd2;
    @(posedge clk); #1 cfg_start = 1'b0;
    rdy_mode = 1;
    wait_idle(200);
    repeat (6) @(posedge clk);
    chk("ignored_start_done_count", done_cnt, exp_done);

    // reset mid-burst
    base = pop_cnt;
    start_burst(32'h1000, 16'd8);
    for (int n = 0; n < 50 && pop_cnt < base + 2; n++) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    addr_q.delete(); data_q.delete(); last_q.delete();
    last_pending = 0;
    base = done_cnt;
    @(negedge clk);
    check_reset_outputs("midrst");
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      chk("midrst_no_stale", {m_val, done}, 0);
    end
    chk("midrst_no_done", done_cnt, base);
    exp_done = done_cnt;
    start_burst(32'h200, 16'd2);
    wait_idle(100);
    chk("post_rst_done_count", done_cnt, exp_done);

    // address wrap
    start_burst(32'hFFFF_FFF8, 16'd4);
    wait_idle(100);

`ifdef BURST_RD_STRIDE_EN
    cfg_stride = 32'h10;
    start_burst(32'h0, 16'd3);
    wait_idle(100);
    cfg_stride = 32'd4;
`endif

    // randomized bursts
    for (int k = 0; k < 12; k++) begin
      rdy_mode = $urandom_range(1, 2);
`ifdef BURST_RD_STRIDE_EN
      cfg_stride = 32'($urandom_range(0, 8)) << 2;
`endif
      start_burst($urandom & 32'hFFFF_FFFC, 16'($urandom_range(1, 12)));
      wait_idle(600);
    end
    chk("final_done_count", done_cnt, exp_done);
    chk("final_queues_empty", addr_q.size() + data_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
